// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU. ALU inputs are held
// for a class-dependent number of cycles so the multiply paths can be multicycle-constrained.
module alu_arbiter #(
   parameter int N_REQ   = 4,
   parameter int MUL_LAT = 2,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*4-1:0]    req_op,
   input  logic [N_REQ*32-1:0]   req_a,
   input  logic [N_REQ*32-1:0]   req_b,
   output logic [3:0]            alu_op,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   input  logic [31:0]           alu_result,
   input  logic                  alu_done,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_data,
   output logic                  rsp_illegal,
   output logic                  busy
);

   localparam int CNT_W = $clog2(MUL_LAT + 1);

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,
      OP_LSL  = 4'd4,  OP_LSR  = 4'd5,  OP_MUL = 4'd6,  OP_SP1 = 4'd7,
      OP_SP2  = 4'd8,  OP_SP3  = 4'd9,  OP_SP4 = 4'd10, OP_SP5 = 4'd11,
      OP_RES1 = 4'd12, OP_RES2 = 4'd13
   } opcode_t;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [31:0]       alu_a_q, alu_a_d;
   logic [31:0]       alu_b_q, alu_b_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              rsp_ill_q, rsp_ill_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W:0]     idx;
   logic [3:0]        gnt_op;
   logic              op_legal, op_multi;
   logic [N_REQ-1:0]  ready_vec;

   // First valid requester at or after rr_ptr, wrapping at N_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
         if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_id    = idx[ID_W-1:0];
         end
      end
   end

   assign gnt_op = req_op[4*gnt_id +: 4];

   always_comb begin
      op_legal = 1'b0;
      op_multi = 1'b0;
      case (opcode_t'(gnt_op))
         OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_LSL, OP_LSR: op_legal = 1'b1;
         OP_MUL, OP_SP1, OP_SP2, OP_SP3, OP_SP4, OP_SP5: begin
            op_legal = 1'b1;
            op_multi = 1'b1;
         end
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      alu_op_d   = alu_op_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      rsp_data_d = rsp_data_q;
      rsp_ill_d  = rsp_ill_q;
      ready_vec  = '0;
      case (state_q)
         S_IDLE: if (gnt_found) begin
            ready_vec[gnt_id] = 1'b1;
            id_d              = gnt_id;
            if (op_legal) begin
               // Illegal ops never reach the ALU inputs.
               alu_op_d  = gnt_op;
               alu_a_d   = req_a[32*gnt_id +: 32];
               alu_b_d   = req_b[32*gnt_id +: 32];
               cnt_d     = op_multi ? CNT_W'(MUL_LAT) : CNT_W'(1);
               rsp_ill_d = 1'b0;
               state_d   = S_EXEC;
            end else begin
               rsp_data_d = '0;
               rsp_ill_d  = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_EXEC: begin
            if (cnt_q > CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (alu_done) begin
               rsp_data_d = alu_result;
               state_d    = S_RESP;
            end
         end
         S_RESP: if (rsp_ready) begin
            rr_ptr_d = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         alu_op_q   <= OP_NOP;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         rsp_data_q <= '0;
         rsp_ill_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         id_q       <= id_d;
         cnt_q      <= cnt_d;
         alu_op_q   <= alu_op_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         rsp_data_q <= rsp_data_d;
         rsp_ill_q  <= rsp_ill_d;
      end
   end

   // Gate the combinational grant so nothing is offered while reset is held.
   assign req_ready   = rst_n ? ready_vec : '0;
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_id      = id_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_illegal = rsp_ill_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N_REQ=4, MUL_LAT=3); the ALU is stood in for
// by driving alu_result/alu_done with hand-computed values.
module tb_alu_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*4-1:0]  req_op;
   logic [N_REQ*32-1:0] req_a, req_b;
   logic [3:0]          alu_op;
   logic [31:0]         alu_a, alu_b, alu_result;
   logic                alu_done;
   logic                rsp_valid, rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [31:0]         rsp_data;
   logic                rsp_illegal, busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arbiter #(.N_REQ(N_REQ), .MUL_LAT(3), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_done(alu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_illegal(rsp_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[4*r +: 4]  = op;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 4'b0001;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      alu_result = '0;
      alu_done   = 1'b1;
      rsp_ready  = 1'b1;
      #3;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_alu_op",    32'(alu_op),    32'h0);
      chk("rst_alu_a",     alu_a,          32'h0);
      chk("rst_rsp_data",  rsp_data,       32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      req_valid = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // Single 1-cycle op: ADD 5+7 from requester 0
      set_req(0, 4'd1, 32'd5, 32'd7);
      alu_result = 32'd12;
      req_valid  = 4'b0001;
      #1;
      chk("add_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("add_exec_busy",  32'(busy),      32'h1);
      chk("add_exec_nvld",  32'(rsp_valid), 32'h0);
      chk("add_alu_op",     32'(alu_op),    32'h1);
      chk("add_alu_a",      alu_a,          32'd5);
      chk("add_alu_b",      alu_b,          32'd7);
      tick();
      chk("add_rsp_valid",  32'(rsp_valid),   32'h1);
      chk("add_rsp_data",   rsp_data,         32'd12);
      chk("add_rsp_id",     32'(rsp_id),      32'h0);
      chk("add_rsp_ill",    32'(rsp_illegal), 32'h0);
      tick();
      chk("add_done_idle",  32'(busy),        32'h0);

      // Multi-cycle op: SP2 3,2 from requester 1 (rr_ptr now 1)
      set_req(1, 4'd8, 32'd3, 32'd2);
      alu_result = 32'd21;
      req_valid  = 4'b0010;
      #1;
      chk("sp2_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         chk("sp2_alu_op",  32'(alu_op),    32'h8);
         chk("sp2_alu_a",   alu_a,          32'd3);
         chk("sp2_alu_b",   alu_b,          32'd2);
         chk("sp2_no_rsp",  32'(rsp_valid), 32'h0);
         tick();
      end
      chk("sp2_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("sp2_rsp_data",  rsp_data,       32'd21);
      chk("sp2_rsp_id",    32'(rsp_id),    32'h1);
      tick();

      // Illegal RES1 from requester 2 (rr_ptr now 2)
      set_req(2, 4'd12, 32'hDEAD, 32'hBEEF);
      alu_result = 32'h1234_5678;
      req_valid  = 4'b0100;
      #1;
      chk("ill_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      chk("ill_rsp_valid", 32'(rsp_valid),   32'h1);
      chk("ill_rsp_ill",   32'(rsp_illegal), 32'h1);
      chk("ill_rsp_data",  rsp_data,         32'h0);
      chk("ill_rsp_id",    32'(rsp_id),      32'h2);
      chk("ill_alu_op",    32'(alu_op),      32'h8);
      chk("ill_alu_a",     alu_a,            32'd3);
      tick();

      // Backpressure: SUB 2-5 from requester 3, rsp_ready low for 5 cycles
      set_req(3, 4'd2, 32'd2, 32'd5);
      alu_result = 32'hFFFF_FFFD;
      rsp_ready  = 1'b0;
      req_valid  = 4'b1000;
      #1;
      chk("bp_ready", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b0110;
      tick();
      for (int c = 0; c < 5; c++) begin
         alu_result = 32'h0BAD_0BAD;
         chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("bp_rsp_data",  rsp_data,       32'hFFFF_FFFD);
         chk("bp_rsp_id",    32'(rsp_id),    32'h3);
         chk("bp_busy",      32'(busy),      32'h1);
         chk("bp_req_ready", 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_still_busy", 32'(busy), 32'h1);
      tick();
      chk("bp_rsp_fell",  32'(rsp_valid), 32'h0);
      chk("bp_idle",      32'(busy),      32'h0);
      chk("bp_rr_wrap",   32'(req_ready), 32'h2);
      req_valid = '0;
      tick();

      // Reset mid-EXEC: MUL from requester 1, then async reset
      set_req(1, 4'd6, 32'd6, 32'd7);
      alu_result = 32'd42;
      req_valid  = 4'b0010;
      tick();
      req_valid = '0;
      chk("mr_exec_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy",      32'(busy),        32'h0);
      chk("mr_alu_op",    32'(alu_op),      32'h0);
      chk("mr_alu_a",     alu_a,            32'h0);
      chk("mr_alu_b",     alu_b,            32'h0);
      chk("mr_rsp_valid", 32'(rsp_valid),   32'h0);
      chk("mr_rsp_id",    32'(rsp_id),      32'h0);
      chk("mr_rsp_data",  rsp_data,         32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
      end

      // Round-robin with all requesters valid; rr_ptr must be 0 after reset
      for (int r = 0; r < N_REQ; r++) set_req(r, 4'd1, 32'(r), 32'd1);
      alu_result = 32'd77;
      req_valid  = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         #1;
         chk("rr_grant",  32'(req_ready), 32'(1 << (g % N_REQ)));
         tick();
         chk("rr_exec_ready", 32'(req_ready), 32'h0);
         tick();
         chk("rr_rsp_id", 32'(rsp_id), 32'(g % N_REQ));
         chk("rr_rsp_ready0", 32'(req_ready), 32'h0);
         tick();
      end
      req_valid = '0;
      tick();

      // alu_done low stretches EXEC (rr_ptr now 1)
      set_req(1, 4'd3, 32'hF0, 32'h3C);
      alu_done  = 1'b0;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      chk("st_wait_busy", 32'(busy),      32'h1);
      chk("st_wait_nvld", 32'(rsp_valid), 32'h0);
      alu_done   = 1'b1;
      alu_result = 32'h30;
      tick();
      chk("st_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("st_rsp_data",  rsp_data,       32'h30);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
